load_store_unit: RTL and testbench

- Processor-side initiator for the `DataMemory` interface: word address, write enable, write data and read data.
- Accepts byte-addressed load and store requests from the multi-cycle datapath and drives the word-organised memory.
- Loads: byte/halfword extraction with sign or zero extension.
- Sub-word stores: read-modify-write.
- Misaligned and illegal requests return an error response with no memory traffic.

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte-addressed load/store initiator for a word-organised data
//            memory, with sub-word extraction/extension and read-modify-write.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata;

    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    // Reset asserted during WRITE suppresses the strobe so a half-finished
    // read-modify-write never reaches memory.
    assign mem_write_en = (r_state == S_WRITE) && !reset;

    assign w_req_err = (req_size == 2'b11) ||
                       ((req_size == c_SIZE_HALF) && req_addr[0]) ||
                       ((req_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00));

    always_comb begin
        w_byte     = 8'h00;
        w_half     = r_offset[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        w_load_ext = mem_read_data;
        w_merged   = mem_read_data;
        case (r_offset)
            2'd0:    w_byte = mem_read_data[7:0];
            2'd1:    w_byte = mem_read_data[15:8];
            2'd2:    w_byte = mem_read_data[23:16];
            default: w_byte = mem_read_data[31:24];
        endcase
        case (r_size)
            c_SIZE_BYTE: w_load_ext = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_load_ext = {{16{~r_unsigned & w_half[15]}}, w_half};
            default:     w_load_ext = mem_read_data;
        endcase
        if (r_size == c_SIZE_BYTE) begin
            case (r_offset)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_offset[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0] = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_offset       <= 2'b00;
            r_wdata        <= 16'h0000;
            resp_rdata     <= 32'h0;
            resp_err       <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_offset   <= req_addr[1:0];
                        r_wdata    <= req_wdata[15:0];
                        mem_addr   <= req_addr[ADDR_W+1:2];
                        resp_rdata <= 32'h0;
                        if (w_req_err) begin
                            resp_err <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            resp_err <= 1'b0;
                            if (req_write && (req_size == c_SIZE_WORD)) begin
                                mem_write_data <= req_wdata;
                                r_state        <= S_WRITE;
                            end else begin
                                r_state <= S_READ;
                            end
                        end
                    end
                end
                S_READ: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (r_write) begin
                        mem_write_data <= w_merged;
                        r_state        <= S_WRITE;
                    end else begin
                        resp_rdata <= w_load_ext;
                        r_state    <= S_DONE;
                    end
                end
                S_WRITE: r_state <= S_DONE;
                S_DONE: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit with a small
//            registered-read memory model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write_en;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = 6'd0;
    logic [31:0] pl_data = 32'h0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Registered-read memory: data is valid one cycle after the address.
    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr[5:0]];
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_write_en) mem[mem_addr[5:0]] <= mem_write_data;
    end

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request from IDLE at a negedge; returns at the negedge after
    // the response is consumed (or, with resp_ready low, in DONE).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [ADDR_W+1:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic e,
                          output int nwr, output logic [31:0] wdat,
                          output logic [ADDR_W-1:0] waddr);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        lat = 1; nwr = 0; wdat = 32'h0; waddr = '0;
        while (!resp_valid && lat < 20) begin
            if (mem_write_en) begin nwr++; wdat = mem_write_data; waddr = mem_addr; end
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        if (resp_ready) @(negedge clk);
    endtask

    int                lat, nwr;
    logic [31:0]       rd, wdat;
    logic              e;
    logic [ADDR_W-1:0] waddr;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp got valid=%b err=%b exp 0/0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
        checks++; if (mem_addr !== '0 || mem_write_en !== 1'b0 || mem_write_data !== 32'h0) begin
            failures++; $display("FAIL rst_mem got addr=%h we=%b wd=%h exp 0/0/0", mem_addr, mem_write_en, mem_write_data); end
    endtask

    task automatic test_word_store_load();
        do_req(1'b1, 2'b10, 1'b0, 17'd32, 32'd100, lat, rd, e, nwr, wdat, waddr);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ws_latency got %0d exp 2", lat); end
        checks++; if (nwr !== 1 || wdat !== 32'd100 || waddr !== 15'd8) begin
            failures++; $display("FAIL ws_write got n=%0d data=%h addr=%h exp 1/64/8", nwr, wdat, waddr); end
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL ws_pulse got valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
        do_req(1'b0, 2'b10, 1'b0, 17'd32, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (lat !== 3) begin failures++; $display("FAIL wl_latency got %0d exp 3", lat); end
        checks++; if (rd !== 32'd100 || e !== 1'b0 || nwr !== 0) begin
            failures++; $display("FAIL wl_data got %h err=%b nwr=%0d exp 64/0/0", rd, e, nwr); end
        checks++; if (mem_addr !== 15'd8) begin failures++; $display("FAIL idle_addr_hold got %h exp 8", mem_addr); end
    endtask

    task automatic test_extension();
        preload(6'd8, 32'h80FF7F01);
        do_req(1'b0, 2'b00, 1'b0, 17'd34, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (rd !== 32'hFFFFFFFF) begin failures++; $display("FAIL lb_34_signed got %h exp ffffffff", rd); end
        do_req(1'b0, 2'b00, 1'b1, 17'd35, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu_35 got %h exp 00000080", rd); end
        do_req(1'b0, 2'b01, 1'b0, 17'd34, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (rd !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_34_signed got %h exp ffff80ff", rd); end
        do_req(1'b0, 2'b01, 1'b1, 17'd32, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (rd !== 32'h00007F01) begin failures++; $display("FAIL lhu_32 got %h exp 00007f01", rd); end
        do_req(1'b0, 2'b00, 1'b0, 17'd33, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (rd !== 32'h0000007F || lat !== 3) begin failures++; $display("FAIL lb_33_signed got %h lat=%0d exp 0000007f/3", rd, lat); end
    endtask

    task automatic test_rmw();
        preload(6'd8, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 17'd33, 32'h123456AA, lat, rd, e, nwr, wdat, waddr);
        checks++; if (lat !== 4) begin failures++; $display("FAIL sb_latency got %0d exp 4", lat); end
        checks++; if (nwr !== 1 || wdat !== 32'h1122AA44) begin failures++; $display("FAIL sb_merge got n=%0d data=%h exp 1/1122aa44", nwr, wdat); end
        do_req(1'b1, 2'b01, 1'b0, 17'd34, 32'hFFFFBEEF, lat, rd, e, nwr, wdat, waddr);
        checks++; if (nwr !== 1 || wdat !== 32'hBEEFAA44 || rd !== 32'h0 || e !== 1'b0) begin
            failures++; $display("FAIL sh_merge got n=%0d data=%h rd=%h err=%b exp 1/beefaa44/0/0", nwr, wdat, rd, e); end
        checks++; if (mem[8] !== 32'hBEEFAA44) begin failures++; $display("FAIL rmw_mem got %h exp beefaa44", mem[8]); end
    endtask

    task automatic test_errors();
        do_req(1'b0, 2'b10, 1'b0, 17'd32, 32'h0, lat, rd, e, nwr, wdat, waddr);
        do_req(1'b0, 2'b01, 1'b0, 17'd33, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL err_half33 got lat=%0d err=%b rd=%h exp 1/1/0", lat, e, rd); end
        do_req(1'b1, 2'b10, 1'b0, 17'd34, 32'hDEADBEEF, lat, rd, e, nwr, wdat, waddr);
        checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || nwr !== 0) begin
            failures++; $display("FAIL err_word34 got lat=%0d err=%b rd=%h nwr=%0d exp 1/1/0/0", lat, e, rd, nwr); end
        do_req(1'b1, 2'b11, 1'b0, 17'd32, 32'hDEADBEEF, lat, rd, e, nwr, wdat, waddr);
        checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || nwr !== 0) begin
            failures++; $display("FAIL err_size11 got lat=%0d err=%b rd=%h nwr=%0d exp 1/1/0/0", lat, e, rd, nwr); end
        checks++; if (mem[8] !== 32'hBEEFAA44) begin failures++; $display("FAIL err_mem got %h exp beefaa44", mem[8]); end
        do_req(1'b0, 2'b10, 1'b0, 17'd32, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (e !== 1'b0 || rd !== 32'hBEEFAA44) begin failures++; $display("FAIL err_clear got err=%b rd=%h exp 0/beefaa44", e, rd); end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 17'd32, 32'h0, lat, rd, e, nwr, wdat, waddr);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 17'd36; req_wdata = 32'h5A5A5A5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hBEEFAA44 || req_ready !== 1'b0 || mem_write_en !== 1'b0) begin
                failures++; $display("FAIL bp_hold[%0d] got valid=%b rd=%h ready=%b we=%b exp 1/beefaa44/0/0",
                                     i, resp_valid, resp_rdata, req_ready, mem_write_en); end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 15'd8) begin
            failures++; $display("FAIL bp_release got valid=%b ready=%b addr=%h exp 0/1/8", resp_valid, req_ready, mem_addr); end
    endtask

    task automatic test_reset_in_write();
        int pulses;
        preload(6'd8, 32'h11223344);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 17'd32; req_wdata = 32'h00000055;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (mem_write_en !== 1'b1) begin failures++; $display("FAIL rw_in_write got we=%b exp 1", mem_write_en); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_addr !== '0 || mem_write_data !== 32'h0) begin
            failures++; $display("FAIL rw_reset_vals got ready=%b valid=%b addr=%h wd=%h exp 1/0/0/0",
                                 req_ready, resp_valid, mem_addr, mem_write_data); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_write_en || resp_valid) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rw_no_activity got %0d exp 0", pulses); end
        do_req(1'b0, 2'b10, 1'b0, 17'd32, 32'h0, lat, rd, e, nwr, wdat, waddr);
        checks++; if (rd !== 32'h11223344 || e !== 1'b0) begin failures++; $display("FAIL rw_old_data got %h err=%b exp 11223344/0", rd, e); end
    endtask

    task automatic test_top_address();
        do_req(1'b1, 2'b10, 1'b0, 17'h1FFFC, 32'hCAFEF00D, lat, rd, e, nwr, wdat, waddr);
        checks++; if (waddr !== 15'h7FFF || nwr !== 1 || e !== 1'b0 || lat !== 2) begin
            failures++; $display("FAIL top_addr got addr=%h n=%0d err=%b lat=%0d exp 7fff/1/0/2", waddr, nwr, e, lat); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0; resp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_word_store_load();
        test_extension();
        test_rmw();
        test_errors();
        test_backpressure();
        test_reset_in_write();
        test_top_address();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
